neureka_tcdm_port_splitter: RTL and testbench

- Sits between the engine's wide HCI core master port (tcdm or tcdm_weight) and the MP independent 32-bit TCDM interconnect ports.
- Tracks grants per port, so the wide grant no longer requires every port to be granted in the same cycle.
- Buffers per-port read responses that arrive in different cycles, then presents one reassembled wide response.
- One instance per wide port.

---
 rtl/neureka_tcdm_port_splitter_pkg.sv | 13 +
 rtl/neureka_tcdm_port_lane.sv | 90 +++++++++
 rtl/neureka_tcdm_port_splitter.sv | 69 ++++++
 tb/tb_neureka_tcdm_port_splitter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neureka_tcdm_port_splitter_pkg.sv
// Shared constants for the wide-to-narrow TCDM port splitter.
// Sets the engine's wide memory port width and the 32-bit narrow TCDM word geometry.
package neureka_tcdm_port_splitter_pkg;

  localparam int unsigned NEUREKA_MEM_BANDWIDTH_EXT = 128;
  localparam int unsigned TCDM_DW                   = 32;
  localparam int unsigned TCDM_BEW                  = TCDM_DW / 8;

  function automatic logic [31:0] lane_addr(input logic [31:0] base, input int unsigned idx);
    return base + 32'(idx * TCDM_BEW);
  endfunction

endpackage

// File: rtl/neureka_tcdm_port_lane.sv
// One narrow TCDM lane of the splitter: request slicing, sticky grant tracking,
// outstanding-access tracking and a depth-1 response buffer.
module neureka_tcdm_port_lane
  import neureka_tcdm_port_splitter_pkg::*;
#(
  parameter int unsigned LANE_IDX = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                in_req_i,
  input  logic [31:0]         in_add_i,
  input  logic                in_wen_i,
  input  logic [TCDM_BEW-1:0] in_be_i,
  input  logic [TCDM_DW-1:0]  in_data_i,
  input  logic                wide_gnt_i,
  input  logic                wide_r_valid_i,
  output logic                out_req_o,
  input  logic                out_gnt_i,
  output logic [31:0]         out_add_o,
  output logic                out_wen_o,
  output logic [TCDM_BEW-1:0] out_be_o,
  output logic [TCDM_DW-1:0]  out_data_o,
  input  logic [TCDM_DW-1:0]  out_r_data_i,
  input  logic                out_r_valid_i,
  output logic                gnt_ok_o,
  output logic                rsp_ok_o,
  output logic [TCDM_DW-1:0]  r_data_o,
  output logic                busy_o
);

  logic               granted_q, granted_d;
  logic               outstanding_q, outstanding_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [TCDM_DW-1:0] rsp_data_q, rsp_data_d;
  logic               slot_free;
  logic               fire;
  logic               rsp_in;

  assign out_add_o  = lane_addr(in_add_i, LANE_IDX);
  assign out_wen_o  = in_wen_i;
  assign out_be_o   = in_be_i;
  assign out_data_o = in_data_i;

  // The slot frees up in the same cycle the wide response completes, so
  // back-to-back wide requests are not throttled.
  assign slot_free = wide_r_valid_i | (~outstanding_q & ~rsp_valid_q);
  assign out_req_o = in_req_i & ~granted_q & slot_free;
  assign fire      = out_req_o & out_gnt_i;
  assign gnt_ok_o  = granted_q | fire;

  // Responses without a matching outstanding access are dropped.
  assign rsp_in   = out_r_valid_i & outstanding_q;
  assign rsp_ok_o = rsp_valid_q | rsp_in;
  assign r_data_o = rsp_valid_q ? rsp_data_q : out_r_data_i;
  assign busy_o   = granted_q | outstanding_q | rsp_valid_q;

  always_comb begin
    granted_d     = wide_gnt_i ? 1'b0 : (granted_q | fire);
    outstanding_d = fire | (outstanding_q & ~out_r_valid_i);
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    if (wide_r_valid_i) begin
      rsp_valid_d = 1'b0;
    end else if (rsp_in) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = out_r_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      granted_q     <= 1'b0;
      outstanding_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else if (clear_i) begin
      granted_q     <= 1'b0;
      outstanding_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      granted_q     <= granted_d;
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

endmodule

// File: rtl/neureka_tcdm_port_splitter.sv
// Splits one wide HCI core port into MP independent 32-bit TCDM ports, tracking
// per-port grants and reassembling per-port responses into one wide response.
module neureka_tcdm_port_splitter
  import neureka_tcdm_port_splitter_pkg::*;
#(
  parameter int unsigned BW = NEUREKA_MEM_BANDWIDTH_EXT,
  parameter int unsigned MP = BW / 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              in_req_i,
  output logic              in_gnt_o,
  input  logic [31:0]       in_add_i,
  input  logic              in_wen_i,
  input  logic [BW/8-1:0]   in_be_i,
  input  logic [BW-1:0]     in_data_i,
  output logic [BW-1:0]     in_r_data_o,
  output logic              in_r_valid_o,
  output logic [MP-1:0]     out_req_o,
  input  logic [MP-1:0]     out_gnt_i,
  output logic [MP*32-1:0]  out_add_o,
  output logic [MP-1:0]     out_wen_o,
  output logic [MP*4-1:0]   out_be_o,
  output logic [MP*32-1:0]  out_data_o,
  input  logic [MP*32-1:0]  out_r_data_i,
  input  logic [MP-1:0]     out_r_valid_i,
  output logic              busy_o
);

  logic [MP-1:0] gnt_ok;
  logic [MP-1:0] rsp_ok;
  logic [MP-1:0] lane_busy;

  // All three wide handshakes are pure combinational reductions over the lanes.
  assign in_gnt_o     = in_req_i & (&gnt_ok);
  assign in_r_valid_o = &rsp_ok;
  assign busy_o       = |lane_busy;

  for (genvar p = 0; p < MP; p++) begin : g_lane
    neureka_tcdm_port_lane #(
      .LANE_IDX (p)
    ) u_lane (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .in_req_i       (in_req_i),
      .in_add_i       (in_add_i),
      .in_wen_i       (in_wen_i),
      .in_be_i        (in_be_i[4*p +: 4]),
      .in_data_i      (in_data_i[32*p +: 32]),
      .wide_gnt_i     (in_gnt_o),
      .wide_r_valid_i (in_r_valid_o),
      .out_req_o      (out_req_o[p]),
      .out_gnt_i      (out_gnt_i[p]),
      .out_add_o      (out_add_o[32*p +: 32]),
      .out_wen_o      (out_wen_o[p]),
      .out_be_o       (out_be_o[4*p +: 4]),
      .out_data_o     (out_data_o[32*p +: 32]),
      .out_r_data_i   (out_r_data_i[32*p +: 32]),
      .out_r_valid_i  (out_r_valid_i[p]),
      .gnt_ok_o       (gnt_ok[p]),
      .rsp_ok_o       (rsp_ok[p]),
      .r_data_o       (in_r_data_o[32*p +: 32]),
      .busy_o         (lane_busy[p])
    );
  end

endmodule

// File: tb/tb_neureka_tcdm_port_splitter.sv
// Directed bench for neureka_tcdm_port_splitter with BW=128 (four narrow ports)
// and a latency-1 TCDM responder that can be switched to manual responses.
module tb_neureka_tcdm_port_splitter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_req;
  logic          in_gnt;
  logic [31:0]   in_add;
  logic          in_wen;
  logic [15:0]   in_be;
  logic [127:0]  in_data;
  logic [127:0]  in_r_data;
  logic          in_r_valid;
  logic [3:0]    out_req;
  logic [3:0]    gnt_mask;
  logic [127:0]  out_add;
  logic [3:0]    out_wen;
  logic [15:0]   out_be;
  logic [127:0]  out_data;
  logic [127:0]  r_data;
  logic [3:0]    r_valid;
  logic          busy;

  logic          rsp_auto;
  logic [3:0]    auto_rv   = '0;
  logic [127:0]  auto_data = '0;
  logic [3:0]    man_rv;
  logic [127:0]  man_data;
  logic [3:0]    tb_out;
  logic          stray_chk_en;
  logic          sb_en;
  logic [127:0]  sb_q[$];
  int            rsp_cnt;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  neureka_tcdm_port_splitter #(
    .BW (128),
    .MP (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .in_req_i      (in_req),
    .in_gnt_o      (in_gnt),
    .in_add_i      (in_add),
    .in_wen_i      (in_wen),
    .in_be_i       (in_be),
    .in_data_i     (in_data),
    .in_r_data_o   (in_r_data),
    .in_r_valid_o  (in_r_valid),
    .out_req_o     (out_req),
    .out_gnt_i     (gnt_mask),
    .out_add_o     (out_add),
    .out_wen_o     (out_wen),
    .out_be_o      (out_be),
    .out_data_o    (out_data),
    .out_r_data_i  (r_data),
    .out_r_valid_i (r_valid),
    .busy_o        (busy)
  );

  // TCDM model: read word at address a is {16'hC0DE, a[15:0]}, latency 1.
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      auto_rv[p] <= rsp_auto && rst_n && !clear && out_req[p] && gnt_mask[p];
      auto_data[32*p +: 32] <= {16'hC0DE, out_add[32*p +: 16]};
    end
  end

  assign r_valid = auto_rv | man_rv;

  always_comb begin
    r_data = '0;
    for (int p = 0; p < 4; p++)
      r_data[32*p +: 32] = auto_rv[p] ? auto_data[32*p +: 32] : man_data[32*p +: 32];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tb_out <= '0;
    else if (clear) tb_out <= '0;
    else            tb_out <= (tb_out & ~r_valid) | (out_req & gnt_mask);
  end

  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n || clear)
    (in_req && !in_gnt) |=> (in_req && $stable(in_add) && $stable(in_wen)
                             && $stable(in_be) && $stable(in_data)));

  a_no_stray: assert property (@(posedge clk) disable iff (!rst_n || !stray_chk_en)
    (r_valid & ~tb_out) == 4'b0000);

  function automatic logic [127:0] exp_rd(input logic [31:0] a);
    logic [127:0] r;
    r = '0;
    for (int p = 0; p < 4; p++) r[32*p +: 32] = {16'hC0DE, 16'(a + 32'(4 * p))};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_en && rst_n && in_r_valid) begin
      if (sb_q.size() == 0) begin
        chk("stream_unexpected_rsp", 128'(in_r_valid), 128'd0);
      end else begin
        chk($sformatf("stream_rsp_%0d", rsp_cnt), in_r_data, sb_q.pop_front());
      end
      rsp_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    logic got;
    rst_n = 1'b0; clear = 1'b0; in_req = 1'b0; in_add = '0; in_wen = 1'b1;
    in_be = '1; in_data = '0; gnt_mask = '0; rsp_auto = 1'b1;
    man_rv = '0; man_data = '0; stray_chk_en = 1'b1; sb_en = 1'b0; rsp_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_out_req", 128'(out_req), 128'd0);
    chk("reset_r_valid", 128'(in_r_valid), 128'd0);

    // all ports granted, back-to-back reads at 0x100 and 0x180
    next_cycle();
    gnt_mask = 4'hF; in_req = 1'b1; in_add = 32'h100; in_wen = 1'b1; in_be = '1;
    #2;
    chk("rd_out_add", out_add, 128'h0000010C_00000108_00000104_00000100);
    chk("rd_out_req", 128'(out_req), 128'hF);
    chk("rd_gnt", 128'(in_gnt), 128'd1);
    next_cycle();
    in_add = 32'h180;
    #2;
    chk("b2b_gnt", 128'(in_gnt), 128'd1);
    chk("rd_r_valid", 128'(in_r_valid), 128'd1);
    chk("rd_r_data", in_r_data, 128'hC0DE010C_C0DE0108_C0DE0104_C0DE0100);
    next_cycle();
    in_req = 1'b0;
    #2;
    chk("b2b_r_valid", 128'(in_r_valid), 128'd1);
    chk("b2b_r_data", in_r_data, 128'hC0DE018C_C0DE0188_C0DE0184_C0DE0180);
    next_cycle();
    #2;
    chk("rd_idle_r_valid", 128'(in_r_valid), 128'd0);
    chk("rd_idle_busy", 128'(busy), 128'd0);

    // port 2 grant withheld for three cycles
    next_cycle();
    gnt_mask = 4'b1011; in_req = 1'b1; in_add = 32'h200;
    #2;
    chk("stall_c0_req", 128'(out_req), 128'hF);
    chk("stall_c0_gnt", 128'(in_gnt), 128'd0);
    next_cycle();
    #2;
    chk("stall_c1_req", 128'(out_req), 128'h4);
    chk("stall_c1_gnt", 128'(in_gnt), 128'd0);
    chk("stall_c1_r_valid", 128'(in_r_valid), 128'd0);
    next_cycle();
    #2;
    chk("stall_c2_req", 128'(out_req), 128'h4);
    chk("stall_c2_busy", 128'(busy), 128'd1);
    next_cycle();
    gnt_mask = 4'hF;
    #2;
    chk("stall_c3_req", 128'(out_req), 128'h4);
    chk("stall_c3_gnt", 128'(in_gnt), 128'd1);
    chk("stall_c3_r_valid", 128'(in_r_valid), 128'd0);
    next_cycle();
    in_req = 1'b0;
    #2;
    chk("stall_r_valid", 128'(in_r_valid), 128'd1);
    chk("stall_r_data", in_r_data, 128'hC0DE020C_C0DE0208_C0DE0204_C0DE0200);
    next_cycle();
    #2;
    chk("stall_idle_busy", 128'(busy), 128'd0);

    // write with only port 1 byte-enabled
    next_cycle();
    in_req = 1'b1; in_add = 32'h40; in_wen = 1'b0; in_be = 16'h00F0;
    in_data = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    #2;
    chk("wr_be", 128'(out_be), 128'h00F0);
    chk("wr_wen", 128'(out_wen), 128'h0);
    chk("wr_data", out_data, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    chk("wr_gnt", 128'(in_gnt), 128'd1);
    next_cycle();
    in_req = 1'b0; in_wen = 1'b1; in_be = '1; in_data = '0;
    #2;
    chk("wr_r_valid", 128'(in_r_valid), 128'd1);
    next_cycle();
    #2;
    chk("wr_r_valid_single", 128'(in_r_valid), 128'd0);

    // eight streaming reads under random per-port grant stalls
    next_cycle();
    sb_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      in_req = 1'b1; in_add = 32'h400 + 32'(16 * n);
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        gnt_mask = 4'($urandom_range(0, 15));
        #2;
        if (in_gnt) begin
          got = 1'b1;
          sb_q.push_back(exp_rd(in_add));
        end
        next_cycle();
      end
      chk($sformatf("stream_gnt_%0d", n), 128'(got), 128'd1);
    end
    in_req = 1'b0; gnt_mask = 4'hF;
    for (int c = 0; c < 20 && rsp_cnt < 8; c++) next_cycle();
    chk("stream_rsp_count", 128'(rsp_cnt), 128'd8);
    sb_en = 1'b0;
    next_cycle();
    #2;
    chk("stream_idle_busy", 128'(busy), 128'd0);

    // reset while ports 0 and 1 are outstanding, then a late response
    next_cycle();
    rsp_auto = 1'b0; gnt_mask = 4'b0011; in_req = 1'b1; in_add = 32'h300;
    #2;
    chk("rst_pre_gnt", 128'(in_gnt), 128'd0);
    next_cycle();
    #2;
    chk("rst_pre_req", 128'(out_req), 128'hC);
    chk("rst_pre_busy", 128'(busy), 128'd1);
    rst_n = 1'b0; in_req = 1'b0;
    #1;
    chk("rst_busy_now", 128'(busy), 128'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1; stray_chk_en = 1'b0;
    man_rv = 4'b0011; man_data = 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000;
    #2;
    chk("rst_late_r_valid", 128'(in_r_valid), 128'd0);
    next_cycle();
    man_rv = '0;
    #2;
    chk("rst_late_busy", 128'(busy), 128'd0);
    next_cycle();
    stray_chk_en = 1'b1; rsp_auto = 1'b1; gnt_mask = 4'hF;
    in_req = 1'b1; in_add = 32'h310;
    #2;
    chk("rst_next_gnt", 128'(in_gnt), 128'd1);
    next_cycle();
    in_req = 1'b0;
    #2;
    chk("rst_next_r_valid", 128'(in_r_valid), 128'd1);
    chk("rst_next_r_data", in_r_data, 128'hC0DE031C_C0DE0318_C0DE0314_C0DE0310);

    // clear while port 0's response is buffered
    next_cycle();
    rsp_auto = 1'b0; in_req = 1'b1; in_add = 32'h500;
    #2;
    chk("clr_pre_gnt", 128'(in_gnt), 128'd1);
    next_cycle();
    in_req = 1'b0; man_rv = 4'b0001; man_data = 128'h00000000_00000000_00000000_12345678;
    #2;
    chk("clr_partial_r_valid", 128'(in_r_valid), 128'd0);
    next_cycle();
    man_rv = '0;
    #2;
    chk("clr_buffered_busy", 128'(busy), 128'd1);
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    #2;
    chk("clr_busy", 128'(busy), 128'd0);
    rsp_auto = 1'b1; in_req = 1'b1; in_add = 32'h510;
    #2;
    chk("clr_next_gnt", 128'(in_gnt), 128'd1);
    next_cycle();
    in_req = 1'b0;
    #2;
    chk("clr_next_r_valid", 128'(in_r_valid), 128'd1);
    chk("clr_next_r_data", in_r_data, 128'hC0DE051C_C0DE0518_C0DE0514_C0DE0510);
    next_cycle();
    #2;
    chk("clr_end_busy", 128'(busy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
